// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StMiss = 1'b1
    } state_e;

    function automatic int unsigned calc_blk_bits(input int unsigned block_width);
        return block_width + 2;
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned set_width);
        return set_width;
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_width,
                                               input int unsigned set_width,
                                               input int unsigned block_width);
        return addr_width - set_width - block_width - 2;
    endfunction

    // A direct-block configuration still needs a 1-bit offset signal.
    function automatic int unsigned calc_off_w(input int unsigned block_width);
        return (block_width > 0) ? block_width : 1;
    endfunction

    function automatic int unsigned calc_way_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid/tag/data arrays with combinational read
// and whole-line synchronous write.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned SET_WIDTH   = 6,
    parameter int unsigned TAG_W       = 22,
    parameter int unsigned BLOCK_WIDTH = 2,
    parameter int unsigned OFF_W       = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          we_i,
    input  logic [SET_WIDTH-1:0]          idx_i,
    input  logic [OFF_W-1:0]              off_i,
    input  logic [TAG_W-1:0]              wtag_i,
    input  logic [(32 << BLOCK_WIDTH)-1:0] wline_i,
    output logic                          valid_o,
    output logic [TAG_W-1:0]              tag_o,
    output logic [31:0]                   word_o
);

    localparam int unsigned SETS = 1 << SET_WIDTH;

    logic [SETS-1:0]               valid_q;
    logic [TAG_W-1:0]              tag_q  [SETS];
    logic [(32 << BLOCK_WIDTH)-1:0] data_q [SETS];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && we_i) begin
            tag_q[idx_i]  <= wtag_i;
            data_q[idx_i] <= wline_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign word_o  = data_q[idx_i][32 * int'(off_i) +: 32];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache between the fetcher and the memory controller.
// Optional hit/miss counters are enabled with ICACHE_PERF_CNT_EN.
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned SET_WIDTH   = 6,
    parameter int unsigned BLOCK_WIDTH = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           IF2IC_en,
    input  logic [ADDR_WIDTH-1:0]          IF2IC_addr,
    output logic                           IC2IF_en,
    output logic [31:0]                    IC2IF_instr,
    output logic [ADDR_WIDTH-1:0]          IC2IF_pc,
    output logic                           IC2MC_en,
    output logic [ADDR_WIDTH-1:0]          IC2MC_addr,
    input  logic                           MC2IC_en,
    input  logic [(32 << BLOCK_WIDTH)-1:0] MC2IC_block,
    input  logic                           RoB2IC_flush
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                    hit_cnt,
    output logic [31:0]                    miss_cnt
`endif
);

    localparam int unsigned BLK_BITS = calc_blk_bits(BLOCK_WIDTH);
    localparam int unsigned IDX_W    = calc_idx_w(SET_WIDTH);
    localparam int unsigned TAG_W    = calc_tag_w(ADDR_WIDTH, SET_WIDTH, BLOCK_WIDTH);
    localparam int unsigned OFF_W    = calc_off_w(BLOCK_WIDTH);
    localparam int unsigned WAY_W    = calc_way_w(WAYS);
    localparam int unsigned SETS     = 1 << SET_WIDTH;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> BLK_BITS);
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_WIDTH-1:0] a);
        return OFF_W'((a >> 2) & ADDR_WIDTH'((1 << BLOCK_WIDTH) - 1));
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return TAG_W'(a >> (BLK_BITS + SET_WIDTH));
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    discard_q, discard_d;
    logic                    if_en_q, if_en_d;
    logic [31:0]             if_instr_q, if_instr_d;
    logic [ADDR_WIDTH-1:0]   if_pc_q, if_pc_d;
    logic                    mc_en_q, mc_en_d;
    logic [ADDR_WIDTH-1:0]   mc_addr_q, mc_addr_d;
    logic [WAY_W-1:0]        rr_q [SETS];

    logic [IDX_W-1:0]        lookup_idx;
    logic [WAYS-1:0]         way_valid, way_we, hit_vec;
    logic [TAG_W-1:0]        way_tag  [WAYS];
    logic [31:0]             way_word [WAYS];
    logic                    hit, fill, fill_we, use_rr;
    logic [31:0]             hit_word, fill_word;
    logic [WAY_W-1:0]        victim, rr_next;

    // During a miss the arrays are addressed by the latched PC so the fill lands there.
    assign lookup_idx = (state_q == StMiss) ? addr_idx(pc_q) : addr_idx(IF2IC_addr);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SET_WIDTH  (SET_WIDTH),
            .TAG_W      (TAG_W),
            .BLOCK_WIDTH(BLOCK_WIDTH),
            .OFF_W      (OFF_W)
        ) u_way (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .we_i   (way_we[w]),
            .idx_i  (lookup_idx),
            .off_i  (addr_off(IF2IC_addr)),
            .wtag_i (addr_tag(pc_q)),
            .wline_i(MC2IC_block),
            .valid_o(way_valid[w]),
            .tag_o  (way_tag[w]),
            .word_o (way_word[w])
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == addr_tag(IF2IC_addr));
        assign way_we[w]  = fill_we && (victim == WAY_W'(w));
    end

    assign hit       = |hit_vec;
    assign fill_word = MC2IC_block[32 * int'(addr_off(pc_q)) +: 32];
    assign fill_we   = fill && rdy_in && !rst_in;

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_word = hit_word | way_word[w];
        end
    end

    // Lowest invalid way wins; round-robin only when the set is full.
    always_comb begin
        victim = rr_q[lookup_idx];
        use_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = WAY_W'(w);
                use_rr = 1'b0;
            end
        end
        rr_next = (rr_q[lookup_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lookup_idx] + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        if_en_d    = 1'b0;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        mc_en_d    = mc_en_q;
        mc_addr_d  = mc_addr_q;
        fill       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (IF2IC_en && !RoB2IC_flush) begin
                    if (hit) begin
                        if_en_d    = 1'b1;
                        if_instr_d = hit_word;
                        if_pc_d    = IF2IC_addr;
                    end else begin
                        mc_en_d   = 1'b1;
                        mc_addr_d = IF2IC_addr & ~ADDR_WIDTH'((1 << BLK_BITS) - 1);
                        pc_d      = IF2IC_addr;
                        state_d   = StMiss;
                    end
                end
            end
            StMiss: begin
                if (MC2IC_en) begin
                    fill      = 1'b1;
                    mc_en_d   = 1'b0;
                    state_d   = StIdle;
                    discard_d = 1'b0;
                    if (!RoB2IC_flush && !discard_q) begin
                        if_en_d    = 1'b1;
                        if_instr_d = fill_word;
                        if_pc_d    = pc_q;
                    end
                end else if (RoB2IC_flush) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            discard_q  <= 1'b0;
            if_en_q    <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            mc_en_q    <= 1'b0;
            mc_addr_q  <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            if_en_q    <= if_en_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            mc_en_q    <= mc_en_d;
            mc_addr_q  <= mc_addr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (fill_we && use_rr) begin
            rr_q[lookup_idx] <= rr_next;
        end
    end

    assign IC2IF_en    = if_en_q;
    assign IC2IF_instr = if_instr_q;
    assign IC2IF_pc    = if_pc_q;
    assign IC2MC_en    = mc_en_q;
    assign IC2MC_addr  = mc_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        lookup;

    assign lookup = (state_q == StIdle) && IF2IC_en && !RoB2IC_flush;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in && lookup) begin
            if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: directed scenarios followed by randomized traffic
// checked against a per-set tag/valid/round-robin model.
module tb_icache_sa;

    localparam int unsigned NSETS = 64;
    localparam int unsigned NWAYS = 2;

    logic         clk = 1'b0;
    logic         rst, rdy, if_en, mc_en_in, flush;
    logic [31:0]  if_addr;
    logic [127:0] mc_block;
    logic         ic_if_en, ic_mc_en;
    logic [31:0]  ic_instr, ic_pc, ic_mc_addr;

    icache_sa #(
        .ADDR_WIDTH (32),
        .WAYS       (2),
        .SET_WIDTH  (6),
        .BLOCK_WIDTH(2)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .rdy_in      (rdy),
        .IF2IC_en    (if_en),
        .IF2IC_addr  (if_addr),
        .IC2IF_en    (ic_if_en),
        .IC2IF_instr (ic_instr),
        .IC2IF_pc    (ic_pc),
        .IC2MC_en    (ic_mc_en),
        .IC2MC_addr  (ic_mc_addr),
        .MC2IC_en    (mc_en_in),
        .MC2IC_block (mc_block),
        .RoB2IC_flush(flush)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: what each set holds, independent of any array layout.
    int unsigned mtag [NSETS][NWAYS];
    bit          mval [NSETS][NWAYS];
    int unsigned mrr  [NSETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] blk, k;
        blk = a & ~32'hF;
        k   = (a >> 2) & 32'h3;
        if (blk == 32'h100) return k + 32'd1;
        return (blk * 32'h9E3779B1) ^ (k * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] a);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) b[32*k +: 32] = mem_word((a & ~32'hF) + 32'(4 * k));
        return b;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int unsigned s = (a >> 4) % NSETS;
        int unsigned t = a >> 10;
        for (int w = 0; w < NWAYS; w++) if (mval[s][w] && mtag[s][w] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int unsigned s = (a >> 4) % NSETS;
        int v = -1;
        for (int w = 0; w < NWAYS; w++) if (v < 0 && !mval[s][w]) v = w;
        if (v < 0) begin
            v = int'(mrr[s]);
            mrr[s] = (mrr[s] + 1) % NWAYS;
        end
        mval[s][v] = 1'b1;
        mtag[s][v] = a >> 10;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < NSETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < NWAYS; w++) mval[s][w] = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_answer(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        e.cyc   = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missing_answer: got none, expected pc %h at cycle %0d",
                         sb[0].pc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (ic_if_en) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_answer: got pc %h at cycle %0d, expected none",
                             ic_pc, cyc);
                end else begin
                    exp_t e = sb.pop_front();
                    check("answer_pc", ic_pc, e.pc);
                    check("answer_instr", ic_instr, e.instr);
                end
            end
        end
    endtask

    task automatic serve(input logic [31:0] a, input int delay, input int flush_at);
        bit discard = 1'b0;
        for (int d = 0; d < delay; d++) begin
            flush = (d == flush_at);
            step();
            if (flush) discard = 1'b1;
            flush = 1'b0;
            check("refill_held", 32'(ic_mc_en), 32'd1);
        end
        mc_en_in = 1'b1;
        mc_block = mem_block(a);
        flush    = (flush_at == delay);
        m_fill(a);
        if (!discard && flush_at != delay) expect_answer(a);
        step();
        mc_en_in = 1'b0;
        flush    = 1'b0;
        check("refill_done", 32'(ic_mc_en), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input int delay, input int flush_at);
        if_en   = 1'b1;
        if_addr = a;
        if (m_hit(a)) begin
            expect_answer(a);
            step();
            if_en = 1'b0;
            check("hit_no_refill", 32'(ic_mc_en), 32'd0);
        end else begin
            step();
            if_en = 1'b0;
            check("miss_req", 32'(ic_mc_en), 32'd1);
            check("miss_addr", ic_mc_addr, a & ~32'hF);
            serve(a, delay, flush_at);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        if_en    = 1'b0;
        if_addr  = '0;
        mc_en_in = 1'b0;
        mc_block = '0;
        flush    = 1'b0;
        m_reset();
        fork
            monitor();
        join_none
        step();
        step();
        rst = 1'b0;
        check("rst_if_en", 32'(ic_if_en), 32'd0);
        check("rst_mc_en", 32'(ic_mc_en), 32'd0);
        check("rst_mc_addr", ic_mc_addr, 32'd0);
        check("rst_instr", ic_instr, 32'd0);
        check("rst_pc", ic_pc, 32'd0);

        // Cold miss, then a fill answering word 1, then streaming hits.
        fetch(32'h104, 2, -1);
        fetch(32'h100, 0, -1);
        fetch(32'h104, 0, -1);
        fetch(32'h108, 0, -1);
        fetch(32'h10C, 0, -1);

        // Three blocks into one set of a 2-way cache.
        fetch(32'h1100, 1, -1);
        fetch(32'h2100, 0, -1);
        fetch(32'h1104, 0, -1);
        fetch(32'h100, 1, -1);

        // Flush while waiting for refill, then the line must be present.
        fetch(32'h200, 5, 2);
        fetch(32'h200, 0, -1);

        // Flush coinciding with refill data, then flush during a hit.
        fetch(32'h300, 3, 3);
        fetch(32'h304, 0, -1);
        if_en   = 1'b1;
        if_addr = 32'h300;
        flush   = 1'b1;
        step();
        if_en = 1'b0;
        flush = 1'b0;
        check("flush_hit_dropped", 32'(ic_if_en), 32'd0);

        // Frozen while MC pulses: nothing must move.
        if_en   = 1'b1;
        if_addr = 32'h400;
        step();
        if_en = 1'b0;
        check("frz_miss_req", 32'(ic_mc_en), 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mc_en_in = (i == 1);
            mc_block = mem_block(32'h9990);
            if_en    = 1'b1;
            if_addr  = 32'h104;
            step();
            check("frz_mc_held", 32'(ic_mc_en), 32'd1);
            check("frz_no_answer", 32'(ic_if_en), 32'd0);
        end
        rdy      = 1'b1;
        mc_en_in = 1'b0;
        if_en    = 1'b0;
        serve(32'h400, 1, -1);

        // Reset in the middle of a miss wipes every line.
        if_en   = 1'b1;
        if_addr = 32'h500;
        step();
        if_en = 1'b0;
        check("rst_miss_req", 32'(ic_mc_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
        check("midrst_mc_en", 32'(ic_mc_en), 32'd0);
        check("midrst_if_en", 32'(ic_if_en), 32'd0);
        fetch(32'h104, 1, -1);
        fetch(32'h200, 0, -1);

        // Stray refill data while idle must not allocate.
        mc_en_in = 1'b1;
        mc_block = mem_block(32'h600);
        step();
        mc_en_in = 1'b0;
        fetch(32'h600, 0, -1);

        for (int it = 0; it < 400; it++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) |
                             ($urandom_range(0, 3) << 2);
            if (r == 0) begin
                mc_en_in = 1'b1;
                mc_block = mem_block(a);
                step();
                mc_en_in = 1'b0;
            end else if (r == 1) begin
                if_en   = 1'b1;
                if_addr = a;
                flush   = 1'b1;
                step();
                if_en = 1'b0;
                flush = 1'b0;
            end else if (r == 2) begin
                step();
            end else begin
                int dly = int'($urandom_range(0, 4));
                int fat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, dly)) : -1;
                fetch(a, dly, fat);
            end
        end

        step();
        step();
        step();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
